mchan_cmd_assembler_ipa: RTL
============================

# mchan_cmd_assembler_ipa

Producer-side front end of the mchan transaction queue. It accepts three-word DMA commands from the core control port and checks them. Each command gets a transaction ID (TID) from a free pool. The block then pushes one packed entry into the transaction queue using the queue's req/gnt handshake. TIDs go back to the pool when the tx/rx engines report completion.

## Interface
- TCDM_ADD_WIDTH, 16, TCDM address field width (≤32)
- EXT_ADD_WIDTH, 16, external address field width (≤32)
- MCHAN_LEN_WIDTH, 16, length field width (≤31)
- TID_WIDTH, 2, TID width; pool size 2**TID_WIDTH
- TRANS_QUEUE_WIDTH, MCHAN_LEN_WIDTH+TCDM_ADD_WIDTH+EXT_ADD_WIDTH+1+TID_WIDTH, entry width
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- cmd_req_i  in  1  command word valid
- cmd_gnt_o  out  1  command word accepted when high together with cmd_req_i
- cmd_dat_i  in  32  command word
- trans_req_o  out  1  entry valid toward the transaction queue
- trans_gnt_i  in  1  queue accepts the entry
- trans_dat_o  out  TRANS_QUEUE_WIDTH  packed entry
- tid_rel_i  in  1  release strobe from the completion logic
- tid_rel_id_i  in  TID_WIDTH  TID being released
- tid_free_cnt_o  out  TID_WIDTH+1  number of free TIDs
- err_o  out  1  one-cycle pulse when a command is dropped

## Operation
- Command words, in order:
  - W0: len = cmd_dat_i[MCHAN_LEN_WIDTH-1:0]; type = cmd_dat_i[MCHAN_LEN_WIDTH] (0 = tx, 1 = rx)
  - W1: TCDM address in the low TCDM_ADD_WIDTH bits
  - W2: external address in the low EXT_ADD_WIDTH bits
  - Upper unused bits are ignored.
- Entry packing, LSB first: len; tcdm; ext; type at bit MCHAN_LEN_WIDTH+TCDM_ADD_WIDTH+EXT_ADD_WIDTH; TID in the top TID_WIDTH bits.
- FSM states: WORD0, WORD1, WORD2, WAIT_TID, PUSH.
  - WORD0 → WORD1 on accept. len, type and the drop flag are latched.
  - WORD1 → WORD2 on accept.
  - WORD2 accept with drop flag set → WORD0. No TID is taken.
  - WORD2 accept with a free TID → PUSH. The TID is reserved in the same edge.
  - WORD2 accept with no free TID → WAIT_TID.
  - WAIT_TID → PUSH when a free TID exists. The TID is reserved in the same edge.
  - PUSH → WORD0 on trans_req_o && trans_gnt_i.
- cmd_gnt_o = 1 in WORD0/1/2 and 0 in WAIT_TID/PUSH.
- trans_req_o = 1 only in PUSH.
- trans_dat_o is registered and stable for the whole time trans_req_o is high.
- TID pool: a busy vector with one bit per TID.
  - Reserve picks the lowest-index free TID, based on the registered busy vector.
  - A release clears the busy bit at the next edge. Releasing a TID that is not busy is ignored.
  - Reserve and release in the same cycle always target different TIDs, so both take effect.
- tid_free_cnt_o = count of zero bits in the registered busy vector.
- After a reset, all TIDs are free.

## Timing
- Reset values: FSM in WORD0; cmd_gnt_o=1; trans_req_o=0; trans_dat_o=0; err_o=0; busy vector=0; tid_free_cnt_o=2**TID_WIDTH.
- Reset asserted mid-command discards any partial command and any pending push. All TIDs become free.
- Minimum timing: W0/W1/W2 accepted on cycles n, n+1, n+2; trans_req_o is high at n+3. If trans_gnt_i is high at n+3, the next W0 can be accepted at n+4. Throughput is one command per 4 cycles.
- cmd_req_i may be deasserted between words. The FSM holds its state.
- While trans_gnt_i is low, trans_req_o and trans_dat_o are held.
- err_o rises in the cycle after the W2 accept of a dropped command.

## Configuration
- MCHAN_IPA_LEN_CHECK_EN defined: a command with len == 0 sets the drop flag. All three words are still consumed. No entry and no TID are issued, and err_o pulses.
- MCHAN_IPA_LEN_CHECK_EN undefined: there is no length check. A zero-length command is pushed like any other, and err_o is tied to 0.

## Test plan
- Reset, then the words 0x0000_0040, 0x0000_1000, 0x0000_8000 back-to-back with trans_gnt_i=1 → one push at cycle 4 of tx len 0x40, tcdm 0x1000, ext 0x8000, TID 0; tid_free_cnt_o goes 4→3.
- Five commands with rx type bit set (W0=0x0001_0010), no releases → TIDs 0,1,2,3 pushed; the fifth parks in WAIT_TID with cmd_gnt_o=0. Then tid_rel_i with id 2 → the fifth is pushed with TID 2 two cycles later.
- Hold trans_gnt_i=0 for 5 cycles in PUSH → trans_req_o stays high, trans_dat_o is unchanged, cmd_gnt_o=0; after grant the FSM returns to WORD0.
- With MCHAN_IPA_LEN_CHECK_EN, W0=0x0000_0000 → three words accepted, err_o pulses once, no trans_req_o, tid_free_cnt_o unchanged. Without the macro → the command is pushed with len 0.
- Release of an already-free TID 3, and a release on the same edge as a reserve of TID 0 → busy vector correct; tid_free_cnt_o reflects only the valid release.
- rst_i asserted for one cycle after W1 → next word is treated as W0; tid_free_cnt_o=4; trans_req_o=0.

Source files
------------

// File: rtl/mchan_cmd_assembler_ipa.sv
// mchan_cmd_assembler_ipa
// Collects three-word DMA commands from the control port and assigns each a
// TID from a small free pool. It then pushes one packed entry into the
// transaction queue. TIDs return to the pool on completion strobes.
// Optional feature macro: MCHAN_IPA_LEN_CHECK_EN (drop zero-length commands).
module mchan_cmd_assembler_ipa #(
    parameter int TCDM_ADD_WIDTH    = 16,
    parameter int EXT_ADD_WIDTH     = 16,
    parameter int MCHAN_LEN_WIDTH   = 16,
    parameter int TID_WIDTH         = 2,
    parameter int TRANS_QUEUE_WIDTH = MCHAN_LEN_WIDTH + TCDM_ADD_WIDTH + EXT_ADD_WIDTH + 1 + TID_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_req_i,
    output logic                         cmd_gnt_o,
    input  logic [31:0]                  cmd_dat_i,
    output logic                         trans_req_o,
    input  logic                         trans_gnt_i,
    output logic [TRANS_QUEUE_WIDTH-1:0] trans_dat_o,
    input  logic                         tid_rel_i,
    input  logic [TID_WIDTH-1:0]         tid_rel_id_i,
    output logic [TID_WIDTH:0]           tid_free_cnt_o,
    output logic                         err_o
);

    localparam int NUM_TIDS = 2 ** TID_WIDTH;
    localparam int TCDM_LSB = MCHAN_LEN_WIDTH;
    localparam int EXT_LSB  = TCDM_LSB + TCDM_ADD_WIDTH;
    localparam int TYPE_BIT = EXT_LSB + EXT_ADD_WIDTH;
    localparam int TID_LSB  = TYPE_BIT + 1;

    typedef enum logic [2:0] {
        WORD0,
        WORD1,
        WORD2,
        WAIT_TID,
        PUSH
    } state_e;

    state_e                         state_q, state_d;
    logic [TRANS_QUEUE_WIDTH-1:0]   dat_q, dat_d;
    logic                           drop_q, drop_d;
    logic                           err_q, err_d;
    logic [NUM_TIDS-1:0]            busy_q, busy_d;
    logic [TID_WIDTH-1:0]           free_tid;
    logic                           any_free;
    logic                           reserve;
    logic                           len_drop;
    logic [TID_WIDTH:0]             free_cnt;
    logic                           cmd_unused;

    // Upper command bits beyond the field widths carry no meaning.
    assign cmd_unused = ^cmd_dat_i;

`ifdef MCHAN_IPA_LEN_CHECK_EN
    assign len_drop = (cmd_dat_i[MCHAN_LEN_WIDTH-1:0] == '0);
`else
    // No length check: drop flag never sets, so err_q stays at its reset value.
    assign len_drop = 1'b0;
`endif

    // Lowest-index free TID, taken from the registered busy vector.
    always_comb begin
        free_tid = '0;
        any_free = 1'b0;
        for (int i = NUM_TIDS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_tid = TID_WIDTH'(i);
                any_free = 1'b1;
            end
        end
    end

    // Population count of free TIDs.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < NUM_TIDS; i++) begin
            if (!busy_q[i]) free_cnt = free_cnt + (TID_WIDTH + 1)'(1);
        end
    end

    // Command FSM: gathers fields directly into the entry register, then
    // reserves a TID and holds the entry until the queue grants it.
    always_comb begin
        state_d     = state_q;
        dat_d       = dat_q;
        drop_d      = drop_q;
        err_d       = 1'b0;
        reserve     = 1'b0;
        cmd_gnt_o   = 1'b0;
        trans_req_o = 1'b0;
        case (state_q)
            WORD0: begin
                cmd_gnt_o = 1'b1;
                if (cmd_req_i) begin
                    dat_d[TCDM_LSB-1:0] = cmd_dat_i[MCHAN_LEN_WIDTH-1:0];
                    dat_d[TYPE_BIT]     = cmd_dat_i[MCHAN_LEN_WIDTH];
                    drop_d              = len_drop;
                    state_d             = WORD1;
                end
            end
            WORD1: begin
                cmd_gnt_o = 1'b1;
                if (cmd_req_i) begin
                    dat_d[EXT_LSB-1:TCDM_LSB] = cmd_dat_i[TCDM_ADD_WIDTH-1:0];
                    state_d                   = WORD2;
                end
            end
            WORD2: begin
                cmd_gnt_o = 1'b1;
                if (cmd_req_i) begin
                    dat_d[TYPE_BIT-1:EXT_LSB] = cmd_dat_i[EXT_ADD_WIDTH-1:0];
                    if (drop_q) begin
                        err_d   = 1'b1;
                        state_d = WORD0;
                    end else if (any_free) begin
                        reserve                         = 1'b1;
                        dat_d[TID_LSB +: TID_WIDTH]     = free_tid;
                        state_d                         = PUSH;
                    end else begin
                        state_d = WAIT_TID;
                    end
                end
            end
            WAIT_TID: begin
                if (any_free) begin
                    reserve                     = 1'b1;
                    dat_d[TID_LSB +: TID_WIDTH] = free_tid;
                    state_d                     = PUSH;
                end
            end
            PUSH: begin
                trans_req_o = 1'b1;
                if (trans_gnt_i) state_d = WORD0;
            end
            default: state_d = WORD0;
        endcase
    end

    // Busy vector update: release and reserve never name the same TID.
    always_comb begin
        busy_d = busy_q;
        if (tid_rel_i) busy_d[tid_rel_id_i] = 1'b0;
        if (reserve)   busy_d[free_tid]     = 1'b1;
    end

    // State registers with synchronous reset; reset frees every TID.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WORD0;
            dat_q   <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign trans_dat_o    = dat_q;
    assign tid_free_cnt_o = free_cnt;
    assign err_o          = err_q;

endmodule
